// File: rtl/din_debounce.sv
// din_debounce: synchronise a raw bouncy input and accept a new level only
// after STABLE_CYCLES consecutive equal samples.
//
// Ports:
//   clk     in  : clock, all state updates on rising edge
//   rst     in  : asynchronous active-high reset
//   din_raw in  : raw asynchronous input (may bounce)
//   dout    out : debounced level (registered)
//   rise    out : one-cycle strobe on dout 0->1 (registered)
//   fall    out : one-cycle strobe on dout 1->0 (registered)
//
// Parameters:
//   STABLE_CYCLES : equal samples needed to accept a level (2 .. 2^CNT_W-1)
//   CNT_W         : stability counter width
//
// Build option:
//   DIN_DEBOUNCE_SYNC_EN defined   -> 2-flop synchroniser ahead of the FSM
//   DIN_DEBOUNCE_SYNC_EN undefined -> single sample register (din_raw must
//                                     already be synchronous to clk)

module din_debounce #(
    parameter int unsigned STABLE_CYCLES = 4,
    parameter int unsigned CNT_W         = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic din_raw,
    output logic dout,
    output logic rise,
    output logic fall
);

    typedef enum logic [1:0] {
        S_LOW    = 2'd0,
        S_WAIT_H = 2'd1,
        S_HIGH   = 2'd2,
        S_WAIT_L = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] LP_LAST = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] LP_ONE  = CNT_W'(1);

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_dout;
    logic             r_rise;
    logic             r_fall;
    logic             w_s;

`ifdef DIN_DEBOUNCE_SYNC_EN
    logic r_sync1;
    logic r_sync2;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= din_raw;
            r_sync2 <= r_sync1;
        end
    end

    assign w_s = r_sync2;
`else
    logic r_samp;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_samp <= 1'b0;
        end else begin
            r_samp <= din_raw;
        end
    end

    assign w_s = r_samp;
`endif

    // The sample that moves us into a WAIT state already counts as the
    // first stable sample, hence cnt<=1 on entry and acceptance at LAST.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_LOW;
            r_cnt   <= '0;
            r_dout  <= 1'b0;
            r_rise  <= 1'b0;
            r_fall  <= 1'b0;
        end else begin
            r_rise <= 1'b0;
            r_fall <= 1'b0;
            unique case (r_state)
                S_LOW: begin
                    if (w_s) begin
                        r_state <= S_WAIT_H;
                        r_cnt   <= LP_ONE;
                    end
                end
                S_WAIT_H: begin
                    if (!w_s) begin
                        r_state <= S_LOW;
                        r_cnt   <= '0;
                    end else if (r_cnt == LP_LAST) begin
                        r_state <= S_HIGH;
                        r_dout  <= 1'b1;
                        r_rise  <= 1'b1;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt + LP_ONE;
                    end
                end
                S_HIGH: begin
                    if (!w_s) begin
                        r_state <= S_WAIT_L;
                        r_cnt   <= LP_ONE;
                    end
                end
                S_WAIT_L: begin
                    if (w_s) begin
                        r_state <= S_HIGH;
                        r_cnt   <= '0;
                    end else if (r_cnt == LP_LAST) begin
                        r_state <= S_LOW;
                        r_dout  <= 1'b0;
                        r_fall  <= 1'b1;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt + LP_ONE;
                    end
                end
                default: begin
                    r_state <= S_LOW;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

    assign dout = r_dout;
    assign rise = r_rise;
    assign fall = r_fall;

endmodule

// File: tb/tb_din_debounce.sv
// tb_din_debounce: scoreboard bench for din_debounce.
// Expected {dout,rise,fall} per edge come from a sliding-window model.

module tb_din_debounce;

    localparam int STABLE = 4;
    localparam int CNT_W  = 8;
`ifdef DIN_DEBOUNCE_SYNC_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic clk = 1'b0;
    logic rst;
    logic din_raw;
    logic dout;
    logic rise;
    logic fall;

    din_debounce #(
        .STABLE_CYCLES(STABLE),
        .CNT_W        (CNT_W)
    ) u_dut (
        .clk    (clk),
        .rst    (rst),
        .din_raw(din_raw),
        .dout   (dout),
        .rise   (rise),
        .fall   (fall)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    logic [2:0] exp_q[$];

    // model: input delay line then window of the last STABLE samples
    logic pipe[LAT];
    logic win[STABLE];
    logic m_dout;

    int edge_no;
    int rise_edge;
    int fall_edge;
    int n_rise;
    int n_fall;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic m_clear();
        for (int i = 0; i < LAT; i++) pipe[i] = 1'b0;
        for (int i = 0; i < STABLE; i++) win[i] = 1'b0;
        m_dout = 1'b0;
    endtask

    task automatic m_step(input logic d, output logic [2:0] e);
        logic s;
        logic all_opp;
        s = pipe[LAT-1];
        for (int i = LAT - 1; i > 0; i--) pipe[i] = pipe[i-1];
        pipe[0] = d;
        for (int i = STABLE - 1; i > 0; i--) win[i] = win[i-1];
        win[0] = s;
        all_opp = 1'b1;
        for (int i = 0; i < STABLE; i++)
            if (win[i] == m_dout) all_opp = 1'b0;
        if (all_opp) begin
            m_dout = ~m_dout;
            e = {m_dout, m_dout, ~m_dout};
        end else begin
            e = {m_dout, 2'b00};
        end
    endtask

    task automatic cycle(input logic d, input string tag);
        logic [2:0] e;
        logic [2:0] got_e;
        din_raw = d;
        if (rst) begin
            m_clear();
            e = 3'b000;
        end else begin
            m_step(d, e);
        end
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        edge_no++;
        got_e = exp_q.pop_front();
        chk(tag, {29'd0, dout, rise, fall}, {29'd0, got_e});
        if (rise) begin
            rise_edge = edge_no;
            n_rise++;
        end
        if (fall) begin
            fall_edge = edge_no;
            n_fall++;
        end
    endtask

    task automatic run(input logic d, input int n, input string tag);
        for (int i = 0; i < n; i++) cycle(d, tag);
    endtask

    task automatic mark();
        edge_no   = 0;
        rise_edge = -1;
        fall_edge = -1;
        n_rise    = 0;
        n_fall    = 0;
    endtask

    initial begin
        logic d;
        m_clear();
        mark();
        rst     = 1'b1;
        din_raw = 1'b1;
        #1;
        chk("rst_pre_edge", {29'd0, dout, rise, fall}, 32'd0);

        // reset held with din_raw high, then release
        run(1'b1, 3, "rst_hold");
        rst = 1'b0;
        mark();
        run(1'b1, 10, "rst_release");
        chk("rst_rise_lat", rise_edge, STABLE + LAT);
        chk("rst_rise_cnt", n_rise, 1);

        // clean fall then clean rise
        mark();
        run(1'b0, 10, "clean_fall");
        chk("fall_lat", fall_edge, STABLE + LAT);
        chk("fall_cnt", n_fall, 1);
        mark();
        run(1'b1, 10, "clean_rise");
        chk("rise_lat", rise_edge, STABLE + LAT);
        chk("rise_cnt", n_rise, 1);
        run(1'b0, 10, "clean_back_low");

        // bounce 1,1,0,1,1,1,0 then low
        mark();
        cycle(1'b1, "bounce");
        cycle(1'b1, "bounce");
        cycle(1'b0, "bounce");
        cycle(1'b1, "bounce");
        cycle(1'b1, "bounce");
        cycle(1'b1, "bounce");
        cycle(1'b0, "bounce");
        run(1'b0, 8, "bounce_tail");
        chk("bounce_rise_cnt", n_rise, 0);
        chk("bounce_dout", dout, 1'b0);

        // pulse STABLE-1 wide rejected
        mark();
        run(1'b1, STABLE - 1, "pulse_short");
        run(1'b0, 10, "pulse_short_tail");
        chk("short_rise_cnt", n_rise, 0);

        // pulse STABLE wide accepted, then fall after STABLE lows
        mark();
        run(1'b1, STABLE, "pulse_exact");
        run(1'b0, 12, "pulse_exact_tail");
        chk("exact_rise_cnt", n_rise, 1);
        chk("exact_fall_cnt", n_fall, 1);
        chk("exact_fall_gap", fall_edge - rise_edge, STABLE);

        // async reset mid-count (WAIT_H) between edges
        mark();
        run(1'b1, LAT + 2, "mid_count");
        #3 rst = 1'b1;
        #1;
        chk("async_mid", {29'd0, dout, rise, fall}, 32'd0);
        run(1'b1, 2, "mid_rst_hold");
        rst = 1'b0;
        mark();
        run(1'b1, 10, "mid_release");
        chk("mid_rise_lat", rise_edge, STABLE + LAT);
        chk("mid_rise_cnt", n_rise, 1);

        // async reset while high clears dout without an edge
        chk("pre_high_dout", dout, 1'b1);
        #3 rst = 1'b1;
        #1;
        chk("async_high", {29'd0, dout, rise, fall}, 32'd0);
        run(1'b0, 2, "high_rst_hold");
        rst = 1'b0;
        run(1'b0, 4, "high_release");

        // random bouncy traffic
        d = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 9) < 3) d = ~d;
            cycle(d, "random");
        end
        run(1'b0, 10, "random_tail");

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/din_debounce.md
# din_debounce

Input conditioning stage that sits directly upstream of the synchronous data flip-flop. It takes a raw asynchronous, bouncy single-bit input, synchronises it, and requires it to hold a new level for a programmable number of consecutive clock samples before accepting it. The output is a clean registered level, which drives the flop's `din`, plus one-cycle rise and fall strobes.

## Interface
- `STABLE_CYCLES`, default 4: number of consecutive equal samples required to accept a new level. Legal range is 2 to 2^`CNT_W`-1.
- `CNT_W`, default 8: width of the stability counter.
- `clk` in 1: single clock; all state updates on its rising edge.
- `rst` in 1: asynchronous, active-high reset; clears all state immediately, independent of `clk`.
- `din_raw` in 1: raw asynchronous input, which may bounce.
- `dout` out 1: debounced level (registered).
- `rise` out 1: one-cycle strobe asserted in the same cycle `dout` goes 0→1 (registered).
- `fall` out 1: one-cycle strobe asserted in the same cycle `dout` goes 1→0 (registered).

## Operation
- Sample path `s` is the synchronised copy of `din_raw`. See Configuration for the number of stages.
- FSM has 4 states: LOW, WAIT_H, HIGH, WAIT_L. Counter `cnt` is `CNT_W` bits wide.
- **LOW** (`dout`=0):
  - `s`=1 → WAIT_H, `cnt`←1.
  - Otherwise stay.
- **WAIT_H** (`dout`=0):
  - `s`=0 → LOW, `cnt`←0. This is a bounce; no strobe is generated.
  - `s`=1 and `cnt`==`STABLE_CYCLES`-1 → HIGH, `dout`←1, `rise`←1, `cnt`←0.
  - Otherwise `cnt`←`cnt`+1.
- **HIGH** (`dout`=1):
  - `s`=0 → WAIT_L, `cnt`←1.
  - Otherwise stay.
- **WAIT_L** (`dout`=1):
  - `s`=1 → HIGH, `cnt`←0. No strobe.
  - `s`=0 and `cnt`==`STABLE_CYCLES`-1 → LOW, `dout`←0, `fall`←1, `cnt`←0.
  - Otherwise `cnt`←`cnt`+1.
- `rise` and `fall` are cleared on every edge where they are not set. They are never high together and never high for 2 consecutive cycles.
- `cnt` never exceeds `STABLE_CYCLES`-1, so no wrap-around is possible.
- Reset values:
  - State = LOW.
  - `cnt`=0.
  - All synchroniser flops = 0.
  - `dout`=0, `rise`=0, `fall`=0.
- Reset asserted mid-count or during a strobe cycle: all of the above are cleared immediately and the partial count is discarded. After release, a `din_raw` that is already high must complete a full synchronise-plus-stability sequence before `dout` rises.

## Timing
- Edge 1 is the first rising edge at which `din_raw`=1 is captured.
- With sync enabled, `dout`=1 and `rise`=1 are visible after edge `STABLE_CYCLES`+2.
  - Default `STABLE_CYCLES`=4: visible after edge 6.
- With sync disabled, they are visible after edge `STABLE_CYCLES`+1.
  - Default `STABLE_CYCLES`=4: visible after edge 5.
- Falling latency is symmetric with rising latency.
- A glitch shorter than `STABLE_CYCLES` samples produces no change on `dout`, `rise` or `fall`.
- A glitch at or above `STABLE_CYCLES` samples is accepted as a new level.
- Input changes arriving after `rst` deassertion are processed from the first clock edge after release.

## Configuration
- Macro: `DIN_DEBOUNCE_SYNC_EN`.
- Defined:
  - `s` is taken from a 2-flop synchroniser chain (`din_raw`→sync1→sync2).
  - Metastability-safe for a truly asynchronous `din_raw`.
- Undefined:
  - `s` is taken from a single sample register.
  - Latency is one cycle shorter.
  - Only legal when `din_raw` is already synchronous to `clk`.

## Test plan
- **Reset values:** assert `rst` with `din_raw`=1, then release.
  - Required: `dout`/`rise`/`fall`=0 during reset.
  - Required with sync, `STABLE_CYCLES`=4: `dout`=1 with a single `rise` pulse after edge 6 post-release.
- **Clean step:** `din_raw` 0→1 held high.
  - Required: `rise` high for exactly 1 cycle, coincident with `dout`→1, at the latency given in Timing.
  - Drive `din_raw` 1→0: required `fall` pulse with symmetric latency.
- **Bounce rejection:** `STABLE_CYCLES`=4; `din_raw` pattern 1,1,0,1,1,1,0 at one sample per clock, then held at 0.
  - Required: `dout` stays 0; `rise` is never asserted.
- **Boundary count:**
  - Pulse exactly 3 samples wide → rejected.
  - Pulse exactly 4 samples wide → accepted (`rise` pulse), followed by `fall` after 4 samples of low.
- **Async reset mid-count:** assert `rst` between clock edges while in WAIT_H with `cnt`=2.
  - Required: state cleared immediately without waiting for a clock edge.
  - Required: no `rise` pulse.
  - Required: a fresh full-latency sequence after release.
- **Macro off:** rebuild without `DIN_DEBOUNCE_SYNC_EN` and rerun the clean-step scenario.
  - Required: `rise` after edge 5 (`STABLE_CYCLES`=4).
